// File: rtl/fib_seq_engine_if.sv
// Wishbone classic slave bundle for fib_seq_engine; signal names follow the
// user-project Wishbone port so the wrapper can wire it straight through.
interface fib_seq_engine_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/fib_seq_engine.sv
// Wishbone-controlled Fibonacci/counter sequence generator clocked only by
// wb_clk_i; a clock-enable prescaler paces the steps.
module fib_seq_engine #(
  parameter int          WIDTH     = 30,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             reset_n,
  fib_seq_engine_if.slave  wb,
  output logic [WIDTH-1:0] value_o,
  output logic             step_o,
  output logic             irq_o
);

  localparam logic [7:0] OFS_CTRL   = 8'h00;
  localparam logic [7:0] OFS_DIV    = 8'h04;
  localparam logic [7:0] OFS_SEED0  = 8'h08;
  localparam logic [7:0] OFS_SEED1  = 8'h0C;
  localparam logic [7:0] OFS_VALUE  = 8'h10;
  localparam logic [7:0] OFS_STATUS = 8'h14;
  localparam logic [7:0] OFS_COUNT  = 8'h18;

  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_on, r_mode, r_wrap, r_irq_en;
  logic [31:0]      r_div;
  logic [31:0]      r_cnt;
  logic [WIDTH-1:0] r_seed0, r_seed1;
  logic [WIDTH-1:0] r_a, r_b;
  logic [31:0]      r_count;
  logic             r_ovf;
  logic             r_irq;
  logic             r_step;

  logic             w_acc, w_hit, w_wr;
  logic             w_wr_ctrl, w_wr_div, w_wr_seed0, w_wr_seed1, w_wr_status;
  logic             w_restart, w_w1c;
  logic             w_tick, w_ovf_cond, w_ovf_set, w_step;
  logic [WIDTH:0]   w_sum;
  logic [31:0]      w_rdata;

  // A new access is taken only while ack is low, giving one-cycle ack pulses.
  assign w_acc       = wb.wbs_stb_i & wb.wbs_cyc_i & ~r_ack;
  assign w_hit       = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_wr        = w_acc & wb.wbs_we_i & w_hit;
  assign w_wr_ctrl   = w_wr & (wb.wbs_adr_i[7:0] == OFS_CTRL);
  assign w_wr_div    = w_wr & (wb.wbs_adr_i[7:0] == OFS_DIV);
  assign w_wr_seed0  = w_wr & (wb.wbs_adr_i[7:0] == OFS_SEED0);
  assign w_wr_seed1  = w_wr & (wb.wbs_adr_i[7:0] == OFS_SEED1);
  assign w_wr_status = w_wr & (wb.wbs_adr_i[7:0] == OFS_STATUS);
  assign w_restart   = w_wr_ctrl & wb.wbs_sel_i[0] & wb.wbs_dat_i[4];
  assign w_w1c       = w_wr_status & wb.wbs_sel_i[0] & wb.wbs_dat_i[0];

  assign w_tick     = r_on & (r_cnt == r_div);
  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  assign w_ovf_cond = r_mode ? (&r_a) : w_sum[WIDTH];
  // Restart pre-empts a coincident tick entirely, including overflow detection.
  assign w_ovf_set  = w_tick & ~w_restart & w_ovf_cond;
  assign w_step     = w_tick & ~w_restart & (~w_ovf_cond | r_wrap);

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (wb.wbs_adr_i[7:0])
        OFS_CTRL:   w_rdata = {28'd0, r_irq_en, r_wrap, r_mode, r_on};
        OFS_DIV:    w_rdata = r_div;
        OFS_SEED0:  w_rdata = 32'(r_seed0);
        OFS_SEED1:  w_rdata = 32'(r_seed1);
        OFS_VALUE:  w_rdata = 32'(r_a);
        OFS_STATUS: w_rdata = {30'd0, r_on, r_ovf};
        OFS_COUNT:  w_rdata = r_count;
        default:    w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc & ~wb.wbs_we_i) ? w_rdata : 32'd0;
    end
  end

  // A bus write of CTRL beats the hardware stop on a non-wrapping overflow.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_on     <= 1'b0;
      r_mode   <= 1'b0;
      r_wrap   <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_wr_ctrl && wb.wbs_sel_i[0]) begin
      r_on     <= wb.wbs_dat_i[0];
      r_mode   <= wb.wbs_dat_i[1];
      r_wrap   <= wb.wbs_dat_i[2];
      r_irq_en <= wb.wbs_dat_i[3];
    end else if (w_ovf_set && !r_wrap) begin
      r_on <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_div   <= '0;
      r_seed0 <= '0;
      r_seed1 <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      for (int k = 0; k < 32; k++) begin
        if (w_wr_div && wb.wbs_sel_i[k/8]) r_div[k] <= wb.wbs_dat_i[k];
      end
      for (int k = 0; k < WIDTH; k++) begin
        if (w_wr_seed0 && wb.wbs_sel_i[k/8]) r_seed0[k] <= wb.wbs_dat_i[k];
        if (w_wr_seed1 && wb.wbs_sel_i[k/8]) r_seed1[k] <= wb.wbs_dat_i[k];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!r_on || w_wr_div || w_restart || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // Sticky overflow: a new overflow outranks a coincident write-1-to-clear.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ovf_set)  r_ovf <= 1'b1;
      else if (w_w1c) r_ovf <= 1'b0;
      r_irq <= r_ovf & r_irq_en;
    end
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= {{(WIDTH-1){1'b0}}, 1'b1};
      r_count <= '0;
      r_step  <= 1'b0;
    end else begin
      r_step <= w_step;
      if (w_restart) begin
        r_a     <= r_seed0;
        r_b     <= r_seed1;
        r_count <= '0;
      end else if (w_step) begin
        r_count <= r_count + 32'd1;
        if (w_ovf_cond) begin
          r_a <= r_seed0;
          r_b <= r_seed1;
        end else if (r_mode) begin
          r_a <= r_a + 1'b1;
        end else begin
          r_a <= r_b;
          r_b <= w_sum[WIDTH-1:0];
        end
      end
    end
  end

  assign wb.wbs_ack_o = r_ack;
  assign wb.wbs_dat_o = r_dat;
  assign value_o      = r_a;
  assign step_o       = r_step;
  assign irq_o        = r_irq;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Directed bench for fib_seq_engine (WIDTH=8): register table, sequence
// timing, prescaler, overflow stop/wrap and the coincident-event cases.
module tb_fib_seq_engine;
  localparam int          W    = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_DIV    = BASE + 32'h04;
  localparam logic [31:0] A_SEED0  = BASE + 32'h08;
  localparam logic [31:0] A_SEED1  = BASE + 32'h0C;
  localparam logic [31:0] A_VALUE  = BASE + 32'h10;
  localparam logic [31:0] A_STATUS = BASE + 32'h14;
  localparam logic [31:0] A_COUNT  = BASE + 32'h18;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] value;
  logic         step;
  logic         irq;
  int           checks = 0;
  int           errors = 0;

  fib_seq_engine_if bus ();

  fib_seq_engine #(.WIDTH(W), .BASE_ADDR(BASE)) dut (
    .wb_clk_i (clk),
    .reset_n  (rst_n),
    .wb       (bus),
    .value_o  (value),
    .step_o   (step),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isWrite;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] expRead;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic isWrite, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] sel,
                              input logic [31:0] expRead, input string name);
    vec_t v;
    v.isWrite = isWrite;
    v.addr    = addr;
    v.data    = data;
    v.sel     = sel;
    v.expRead = expRead;
    v.name    = name;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the ack edge.
  task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] sel, output logic [31:0] rdata);
    logic got;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = isWrite;
    bus.wbs_adr_i = addr;
    bus.wbs_dat_i = data;
    bus.wbs_sel_i = sel;
    got = 1'b0;
    for (int n = 0; n < 4 && !got; n++) begin
      @(posedge clk);
      @(negedge clk);
      got = bus.wbs_ack_o;
    end
    checkOutput("bus_ack", {31'd0, got}, 32'd1);
    rdata = bus.wbs_dat_o;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    applyStimulus(1'b1, addr, data, 4'hF, dummy);
  endtask

  task automatic readReg(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] r;
    applyStimulus(1'b0, addr, 32'd0, 4'h0, r);
    checkOutput(name, r, exp);
  endtask

  task automatic runVectors(input int first, input int last);
    logic [31:0] r;
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].isWrite, vecs[i].addr, vecs[i].data, vecs[i].sel, r);
      if (!vecs[i].isWrite) checkOutput(vecs[i].name, r, vecs[i].expRead);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] fibExp [8];
    logic [7:0] lucasExp [6];
    logic [7:0] ctrExp [7];
    fibExp   = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13};
    lucasExp = '{8'd144, 8'd2, 8'd1, 8'd3, 8'd4, 8'd7};
    ctrExp   = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd250};

    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'd0;
    bus.wbs_dat_i = 32'd0;

    vecs.push_back(mk(1'b0, A_CTRL,   32'd0, 4'h0, 32'd0, "rst_ctrl"));
    vecs.push_back(mk(1'b0, A_DIV,    32'd0, 4'h0, 32'd0, "rst_div"));
    vecs.push_back(mk(1'b0, A_SEED0,  32'd0, 4'h0, 32'd0, "rst_seed0"));
    vecs.push_back(mk(1'b0, A_SEED1,  32'd0, 4'h0, 32'd1, "rst_seed1"));
    vecs.push_back(mk(1'b0, A_VALUE,  32'd0, 4'h0, 32'd0, "rst_value"));
    vecs.push_back(mk(1'b0, A_STATUS, 32'd0, 4'h0, 32'd0, "rst_status"));
    vecs.push_back(mk(1'b0, A_COUNT,  32'd0, 4'h0, 32'd0, "rst_count"));
    vecs.push_back(mk(1'b1, A_DIV,    32'h1234_5678, 4'b0101, 32'd0, "wr_div_sel"));
    vecs.push_back(mk(1'b0, A_DIV,    32'd0, 4'h0, 32'h0034_0078, "div_bytelanes"));
    vecs.push_back(mk(1'b1, A_SEED0,  32'hFFFF_FFAB, 4'hF, 32'd0, "wr_seed0"));
    vecs.push_back(mk(1'b0, A_SEED0,  32'd0, 4'h0, 32'h0000_00AB, "seed0_width"));
    vecs.push_back(mk(1'b1, A_SEED0,  32'h0000_00CD, 4'h0, 32'd0, "wr_seed0_nosel"));
    vecs.push_back(mk(1'b0, A_SEED0,  32'd0, 4'h0, 32'h0000_00AB, "seed0_nosel"));
    vecs.push_back(mk(1'b1, BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF, 32'd0, "wr_unmapped"));
    vecs.push_back(mk(1'b0, BASE + 32'h1C, 32'd0, 4'h0, 32'd0, "rd_unmapped"));
    vecs.push_back(mk(1'b1, 32'h4000_0004, 32'd0, 4'hF, 32'd0, "wr_otherbase"));
    vecs.push_back(mk(1'b0, A_DIV,    32'd0, 4'h0, 32'h0034_0078, "div_otherbase"));
    vecs.push_back(mk(1'b0, 32'h4000_0004, 32'd0, 4'h0, 32'd0, "rd_otherbase"));
    vecs.push_back(mk(1'b1, A_DIV,    32'd0, 4'hF, 32'd0, "wr_div0"));
    vecs.push_back(mk(1'b1, A_SEED0,  32'd0, 4'hF, 32'd0, "wr_seed0_0"));
    vecs.push_back(mk(1'b1, A_CTRL,   32'hFFFF_FFE0, 4'hF, 32'd0, "wr_ctrl_unused"));
    vecs.push_back(mk(1'b0, A_CTRL,   32'd0, 4'h0, 32'd0, "ctrl_unused"));
    vecs.push_back(mk(1'b0, A_VALUE,  32'd0, 4'h0, 32'd0, "value_after_seed"));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_value_o", 32'(value), 32'd0);
    checkOutput("rst_step_o", {31'd0, step}, 32'd0);
    checkOutput("rst_irq_o", {31'd0, irq}, 32'd0);
    checkOutput("rst_ack_o", {31'd0, bus.wbs_ack_o}, 32'd0);
    runVectors(0, vecs.size() - 1);

    // Fibonacci at full speed, stopped by a CTRL write that lands on the 7th step.
    writeReg(A_CTRL, 32'h1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("fib_value", 32'(value), 32'(fibExp[i]));
      checkOutput("fib_step", {31'd0, step}, (i > 0) ? 32'd1 : 32'd0);
    end
    writeReg(A_CTRL, 32'h0);
    checkOutput("fib_value7", 32'(value), 32'(fibExp[7]));
    checkOutput("fib_step7", {31'd0, step}, 32'd1);
    readReg(A_COUNT, 32'd7, "fib_count");
    readReg(A_STATUS, 32'd0, "fib_status");
    readReg(A_VALUE, 32'd13, "fib_value_reg");

    // Prescaled by 4, then a DIV rewrite mid-count restarts the spacing.
    writeReg(A_DIV, 32'd3);
    writeReg(A_CTRL, 32'h11);
    checkOutput("pre_value0", 32'(value), 32'd0);
    checkOutput("pre_step0", {31'd0, step}, 32'd0);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      checkOutput("pre_step", {31'd0, step}, (i == 4 || i == 8 || i == 12) ? 32'd1 : 32'd0);
      if (i == 4)  checkOutput("pre_value4", 32'(value), 32'd1);
      if (i == 8)  checkOutput("pre_value8", 32'(value), 32'd1);
      if (i == 12) checkOutput("pre_value12", 32'(value), 32'd2);
    end
    writeReg(A_DIV, 32'd3);
    for (int i = 15; i <= 19; i++) begin
      if (i > 15) @(negedge clk);
      checkOutput("div_rewrite_step", {31'd0, step}, (i == 19) ? 32'd1 : 32'd0);
    end
    checkOutput("div_rewrite_value", 32'(value), 32'd3);

    // Asynchronous reset while running.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_value_o", 32'(value), 32'd0);
    checkOutput("midrst_step_o", {31'd0, step}, 32'd0);
    checkOutput("midrst_irq_o", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runVectors(0, 6);

    // Overflow with wrap=0: halts at 144 (B=233), ovf and irq set.
    writeReg(A_CTRL, 32'h9);
    repeat (12) @(negedge clk);
    checkOutput("stop_value12", 32'(value), 32'd144);
    checkOutput("stop_step12", {31'd0, step}, 32'd1);
    @(negedge clk);
    checkOutput("stop_value13", 32'(value), 32'd144);
    checkOutput("stop_step13", {31'd0, step}, 32'd0);
    checkOutput("stop_irq_lat", {31'd0, irq}, 32'd0);
    @(negedge clk);
    checkOutput("stop_irq", {31'd0, irq}, 32'd1);
    readReg(A_STATUS, 32'h1, "stop_status");
    readReg(A_CTRL, 32'h8, "stop_ctrl");
    readReg(A_COUNT, 32'd12, "stop_count");
    readReg(A_VALUE, 32'd144, "stop_value_reg");
    writeReg(A_STATUS, 32'h1);
    checkOutput("w1c_irq_lat", {31'd0, irq}, 32'd1);
    @(negedge clk);
    checkOutput("w1c_irq", {31'd0, irq}, 32'd0);
    readReg(A_STATUS, 32'h0, "w1c_status");

    // Overflow with wrap=1 reloads the Lucas seeds.
    writeReg(A_SEED0, 32'd2);
    writeReg(A_SEED1, 32'd1);
    writeReg(A_CTRL, 32'h5);
    checkOutput("wrap_value0", 32'(value), 32'(lucasExp[0]));
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      checkOutput("wrap_value", 32'(value), 32'(lucasExp[i]));
      checkOutput("wrap_step", {31'd0, step}, 32'd1);
    end
    readReg(A_STATUS, 32'h3, "wrap_status_run");
    writeReg(A_CTRL, 32'h0);
    readReg(A_STATUS, 32'h1, "wrap_ovf_sticky");

    // Counter mode with wrap; W1C racing an overflow, restart racing a tick.
    writeReg(A_SEED0, 32'd250);
    writeReg(A_STATUS, 32'h1);
    writeReg(A_CTRL, 32'h17);
    checkOutput("ctr_value0", 32'(value), 32'(ctrExp[0]));
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      checkOutput("ctr_value", 32'(value), 32'(ctrExp[i]));
      checkOutput("ctr_step", {31'd0, step}, 32'd1);
    end
    writeReg(A_STATUS, 32'h1);
    checkOutput("ctr_value_r7", 32'(value), 32'd251);
    repeat (4) @(negedge clk);
    writeReg(A_STATUS, 32'h1);
    checkOutput("race_w1c_value", 32'(value), 32'd250);
    readReg(A_STATUS, 32'h3, "race_w1c_ovf");
    @(negedge clk);
    writeReg(A_CTRL, 32'h17);
    checkOutput("race_restart_value", 32'(value), 32'd250);
    checkOutput("race_restart_step", {31'd0, step}, 32'd0);
    @(negedge clk);
    checkOutput("after_restart_value", 32'(value), 32'd251);
    checkOutput("after_restart_step", {31'd0, step}, 32'd1);
    writeReg(A_CTRL, 32'h6);
    readReg(A_COUNT, 32'd2, "restart_count");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fib_seq_engine.md
# fib_seq_engine

Parametrised, Wishbone-controlled sequence generator that replaces the clock-mux-driven Fibonacci core. It runs entirely on `wb_clk_i` and uses a programmable clock-enable prescaler instead of divided clocks. It adds a counter mode, seed loading, overflow detection with a stop-or-wrap policy, a step counter and an interrupt. It sits behind the user-project Wishbone port, and `value_o` drives the IO pads.

## Interface
- `WIDTH`, default 30: sequence width in bits, legal range 2..32.
- `BASE_ADDR`, default 32'h3000_0000: Wishbone base address; only bits [31:8] are decoded.
- `wb_clk_i`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone classic strobe, cycle and write-enable.
- `wbs_sel_i`  in  4  byte-lane enables for writes.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data.
- `value_o`  out  WIDTH  current sequence term (register A).
- `step_o`  out  1  one-cycle pulse on each executed step.
- `irq_o`  out  1  level interrupt, equal to `ovf & irq_en`.

## Operation
- Register map (offsets):
  - 0x00 CTRL, R/W: bit0 `on`; bit1 `mode` (0 = Fibonacci, 1 = counter); bit2 `wrap`; bit3 `irq_en`; bit4 `restart` (write-1 strobe, reads 0).
  - 0x04 DIV, R/W, 32 bits.
  - 0x08 SEED0, R/W, WIDTH bits.
  - 0x0C SEED1, R/W, WIDTH bits.
  - 0x10 VALUE, RO: A.
  - 0x14 STATUS: bit0 `ovf` (sticky, write-1-to-clear); bit1 `running` (RO).
  - 0x18 COUNT, RO: 32-bit step counter that wraps and is cleared by `restart`.
- Bus access rules:
  - Unused bits read 0.
  - Unmapped offsets and non-matching bases: reads return 0, writes are ignored, and the access is still acked.
  - Writes honour `wbs_sel_i` per byte.
- Prescaler:
  - `cnt` increments while `on`=1.
  - `tick` = `on` & (`cnt`==DIV); `cnt` returns to 0 on tick.
  - `cnt` is held at 0 while `on`=0 and is cleared on any DIV write.
- Step on tick:
  - Fibonacci: A←B, B←A+B, with the sum computed at WIDTH+1 bits.
  - Counter: A←A+1, with B unused.
- Overflow is a carry out of WIDTH bits (Fibonacci: A+B ≥ 2^WIDTH; counter: A all ones). On the overflowing tick:
  - `ovf` is set.
  - If `wrap`=0: the step is not performed, A and B hold, `on` is cleared by hardware, and `step_o` stays 0.
  - If `wrap`=1: A←SEED0 and B←SEED1, `step_o` pulses, and COUNT increments.
- `restart`: A←SEED0, B←SEED1, COUNT←0, `cnt`←0. `ovf` is not cleared.
- SEED writes do not affect A or B until the next restart or wrap.
- `running` = `on`.

## Timing
- Reset values:
  - A=0, B=1, SEED0=0, SEED1=1, DIV=0, CTRL=0, `ovf`=0, COUNT=0, `cnt`=0.
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `step_o`=0, `irq_o`=0.
- Reset is asynchronous on assert and is released synchronously to `wb_clk_i`. Reset mid-run returns everything to the reset values immediately.
- Acknowledge: `wbs_ack_o` rises on the edge after `stb&cyc` is sampled (ack ← `stb & cyc & ~ack`) and lasts exactly one cycle. Back-to-back accesses therefore take 2 cycles each.
- Writes update the register on the same edge that asserts ack. Read data is valid while ack is high.
- After an `on` write, the first step happens DIV+1 cycles after the ack edge. Steps then repeat every DIV+1 cycles; DIV=0 means every cycle.
- A, B, `step_o` and COUNT update on the tick edge. `value_o` is registered with no extra latency.
- Simultaneous events:
  - `restart` and tick in the same cycle: restart wins and no step occurs.
  - STATUS W1C and a new overflow in the same cycle: set wins.
  - CTRL write of `on`=1 and a hardware clear from the `wrap`=0 overflow in the same cycle: the bus write wins.
- `irq_o` follows `ovf` and `irq_en` with one register of latency: it asserts the cycle after `ovf` sets.

## Test plan
- Reset: assert `reset_n`=0 mid-sequence, then read all registers → reset values; `value_o`=0, `irq_o`=0.
- Fibonacci at full speed: DIV=0, CTRL=0x1 → `value_o` runs 0,1,1,2,3,5,8,13 on consecutive cycles; `step_o` is high every cycle; COUNT=7 after 7 steps.
- Prescaled: DIV=3 → `value_o` changes exactly every 4 cycles, the first change 4 cycles after the CTRL ack; writing DIV mid-run restarts the 4-cycle spacing.
- Overflow stop (WIDTH=8, `wrap`=0, `irq_en`=1) → A halts at 144 with B=233 (144+233=377 overflows); STATUS reads 0x1, CTRL.`on`=0, `irq_o`=1; writing STATUS=1 clears `irq_o`.
- Overflow wrap (WIDTH=8, `wrap`=1, SEED0=2, SEED1=1) → after overflow the sequence reloads to 2,1,3,4,7 (Lucas); `ovf` stays set.
- Counter mode and race cases (WIDTH=8, `mode`=1, `wrap`=1, SEED0=250) → 250..255, then 250.
  - STATUS W1C issued in the same cycle as the overflow → `ovf` remains 1.
  - `restart` coincident with a tick → A=SEED0 and no step pulse.
